// File: rtl/spi_trig_tx_if.sv
// Request and serial-line bundle for the spi_trig_tx SPI master transmitter.
// hold_full is present only when SPI_TX_QUEUE_EN is defined.
interface spi_trig_tx_if;
    logic        wrt;
    logic [15:0] tx_data;
    logic        edg;
    logic        len8_16;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        busy;
    logic        done;
`ifdef SPI_TX_QUEUE_EN
    logic        hold_full;

    modport master (output wrt, tx_data, edg, len8_16,
                    input  SS_n, SCLK, MOSI, busy, done, hold_full);
    modport slave  (input  wrt, tx_data, edg, len8_16,
                    output SS_n, SCLK, MOSI, busy, done, hold_full);
`else
    modport master (output wrt, tx_data, edg, len8_16,
                    input  SS_n, SCLK, MOSI, busy, done);
    modport slave  (input  wrt, tx_data, edg, len8_16,
                    output SS_n, SCLK, MOSI, busy, done);
`endif
endinterface

// File: rtl/spi_trig_tx.sv
// SPI master transmitter: 8/16-bit MSB-first frames on SS_n/SCLK/MOSI, all outputs registered.
// Optional one-entry request holding register enabled by SPI_TX_QUEUE_EN.
//
// state | meaning
// IDLE  | SS_n=1, SCLK=1, waiting for a request
// FRONT | SS_n=0, SCLK=1 for SCLK_HALF clk, MSB already on MOSI
// SHIFT | SCLK toggles every SCLK_HALF clk, N fall/rise periods
// BACK  | SCLK=1, last bit held, SS_n=0 for SCLK_HALF clk
module spi_trig_tx #(
    parameter int SCLK_HALF = 16
) (
    input  logic         clk,
    input  logic         rst,
    spi_trig_tx_if.slave bus
);
    localparam int              CW      = $clog2(SCLK_HALF);
    localparam logic [CW-1:0]   HC_LAST = CW'(SCLK_HALF - 1);

    typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

    state_t        state;
    logic [CW-1:0] hcnt;
    logic [4:0]    tcnt;
    logic [14:0]   sr;
    logic          edg_q;
    logic          len_q;
    logic          ss_n_q;
    logic          sclk_q;
    logic          mosi_q;
    logic          busy_q;
    logic          done_q;

    logic          start;
    logic [15:0]   start_data;
    logic          start_edg;
    logic          start_len;
    logic [4:0]    tcnt_last;
    logic          advance;

`ifdef SPI_TX_QUEUE_EN
    logic          hold_valid;
    logic [15:0]   hold_data;
    logic          hold_edg;
    logic          hold_len;

    // A held request takes priority over a fresh wrt; the fresh one refills the holding register.
    always_comb begin
        start      = (state == IDLE) && (hold_valid || bus.wrt);
        start_data = hold_valid ? hold_data : bus.tx_data;
        start_edg  = hold_valid ? hold_edg  : bus.edg;
        start_len  = hold_valid ? hold_len  : bus.len8_16;
    end

    assign bus.hold_full = hold_valid;
`else
    always_comb begin
        start      = (state == IDLE) && bus.wrt;
        start_data = bus.tx_data;
        start_edg  = bus.edg;
        start_len  = bus.len8_16;
    end
`endif

    // Even toggle index is a fall, odd is a rise; tcnt_last is the Nth rise.
    always_comb begin
        tcnt_last = len_q ? 5'd31 : 5'd15;
        if (edg_q)
            advance = !tcnt[0] && (tcnt != 5'd0);
        else
            advance = tcnt[0] && (tcnt != tcnt_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            hcnt   <= '0;
            tcnt   <= '0;
            sr     <= '0;
            edg_q  <= 1'b0;
            len_q  <= 1'b0;
            ss_n_q <= 1'b1;
            sclk_q <= 1'b1;
            mosi_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SPI_TX_QUEUE_EN
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_edg   <= 1'b0;
            hold_len   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= FRONT;
                        hcnt   <= '0;
                        tcnt   <= '0;
                        edg_q  <= start_edg;
                        len_q  <= start_len;
                        sr     <= start_len ? start_data[14:0] : {start_data[6:0], 8'h00};
                        mosi_q <= start_len ? start_data[15] : start_data[7];
                        ss_n_q <= 1'b0;
                        sclk_q <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                FRONT: begin
                    if (hcnt == HC_LAST) begin
                        hcnt  <= '0;
                        state <= SHIFT;
                    end else begin
                        hcnt <= hcnt + CW'(1);
                    end
                end
                SHIFT: begin
                    if (hcnt == HC_LAST) begin
                        hcnt   <= '0;
                        sclk_q <= ~sclk_q;
                        tcnt   <= tcnt + 5'd1;
                        if (advance) begin
                            mosi_q <= sr[14];
                            sr     <= {sr[13:0], 1'b0};
                        end
                        if (tcnt == tcnt_last)
                            state <= BACK;
                    end else begin
                        hcnt <= hcnt + CW'(1);
                    end
                end
                BACK: begin
                    if (hcnt == HC_LAST) begin
                        hcnt   <= '0;
                        ss_n_q <= 1'b1;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        hcnt <= hcnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef SPI_TX_QUEUE_EN
            if (state == IDLE) begin
                if (hold_valid) begin
                    hold_valid <= bus.wrt;
                    if (bus.wrt) begin
                        hold_data <= bus.tx_data;
                        hold_edg  <= bus.edg;
                        hold_len  <= bus.len8_16;
                    end
                end
            end else if (bus.wrt && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= bus.tx_data;
                hold_edg   <= bus.edg;
                hold_len   <= bus.len8_16;
            end
`endif
        end
    end

    assign bus.SS_n = ss_n_q;
    assign bus.SCLK = sclk_q;
    assign bus.MOSI = mosi_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_spi_trig_tx.sv
// Directed self-checking bench for spi_trig_tx with a behavioural SPI receive/trigger model.
module tb_spi_trig_tx;
    localparam int H    = 4;
    localparam int WMAX = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    spi_trig_tx_if bus ();

    spi_trig_tx #(.SCLK_HALF(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Receive-side model: samples MOSI on the configured edge while SS_n is low.
    logic        clr      = 1'b0;
    logic        mon_edg  = 1'b1;
    logic        mon_len  = 1'b0;
    logic [15:0] mon_match = 16'h0000;
    logic        sclk_p   = 1'b1;
    logic        ss_p     = 1'b1;
    logic [15:0] rise_sr  = '0;
    logic [15:0] fall_sr  = '0;
    int          fr_r = 0, fr_f = 0;
    int          rises = 0, falls = 0, edges = 0, edges_ss_hi = 0;
    int          done_cnt = 0, frames = 0, trig_cnt = 0;
    logic [15:0] fw [0:7];
    logic [15:0] word;
    int          nsamp;

    always @(negedge clk) begin
        if (clr) begin
            rises = 0; falls = 0; edges = 0; edges_ss_hi = 0;
            done_cnt = 0; frames = 0; trig_cnt = 0;
        end else begin
            if (bus.SS_n === 1'b0 && ss_p === 1'b1) begin
                rise_sr = '0; fall_sr = '0; fr_r = 0; fr_f = 0;
            end
            if (bus.SCLK !== sclk_p) begin
                edges++;
                if (bus.SS_n === 1'b1) edges_ss_hi++;
                else if (bus.SCLK === 1'b1) begin
                    rises++; fr_r++; rise_sr = {rise_sr[14:0], bus.MOSI};
                end else begin
                    falls++; fr_f++; fall_sr = {fall_sr[14:0], bus.MOSI};
                end
            end
            if (bus.done === 1'b1) done_cnt++;
            if (bus.SS_n === 1'b1 && ss_p === 1'b0) begin
                word  = mon_edg ? rise_sr : fall_sr;
                nsamp = mon_edg ? fr_r : fr_f;
                if (!mon_len) word = {8'h00, word[7:0]};
                if (frames < 8) fw[frames] = word;
                frames++;
                if (nsamp == (mon_len ? 16 : 8) &&
                    word == (mon_len ? mon_match : {8'h00, mon_match[7:0]}))
                    trig_cnt++;
            end
        end
        sclk_p = bus.SCLK;
        ss_p   = bus.SS_n;
    end

    task automatic clear_mon();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    // Returns one cycle after the accepting edge; later input changes must be ignored.
    task automatic do_wrt(input logic [15:0] d, input logic e, input logic l);
        @(posedge clk); #1;
        bus.wrt = 1'b1; bus.tx_data = d; bus.edg = e; bus.len8_16 = l;
        @(posedge clk); #1;
        bus.wrt = 1'b0; bus.tx_data = ~d; bus.edg = ~e; bus.len8_16 = ~l;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < WMAX) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic set_mon(input logic e, input logic l, input logic [15:0] m);
        mon_edg = e; mon_len = l; mon_match = m;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.SS_n !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n got=%b exp=1", bus.SS_n); end
        n_checks++; if (bus.SCLK !== 1'b1) begin n_fail++; $display("FAIL reset_sclk got=%b exp=1", bus.SCLK); end
        n_checks++; if (bus.MOSI !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", bus.MOSI); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
`ifdef SPI_TX_QUEUE_EN
        n_checks++; if (bus.hold_full !== 1'b0) begin n_fail++; $display("FAIL reset_hold_full got=%b exp=0", bus.hold_full); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_frame8_edg1();
        int cyc;
        set_mon(1'b1, 1'b0, 16'h00A5);
        clear_mon();
        do_wrt(16'h00A5, 1'b1, 1'b0);
        n_checks++; if (bus.SS_n !== 1'b0) begin n_fail++; $display("FAIL f8_start_ss_n got=%b exp=0", bus.SS_n); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL f8_start_busy got=%b exp=1", bus.busy); end
        n_checks++; if (bus.MOSI !== 1'b1) begin n_fail++; $display("FAIL f8_start_mosi got=%b exp=1", bus.MOSI); end
        n_checks++; if (bus.SCLK !== 1'b1) begin n_fail++; $display("FAIL f8_start_sclk got=%b exp=1", bus.SCLK); end
        wait_done(cyc);
        n_checks++; if (cyc + 1 != 73) begin n_fail++; $display("FAIL f8_wrt_to_done got=%0d exp=73", cyc + 1); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL f8_done_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.SS_n !== 1'b1) begin n_fail++; $display("FAIL f8_done_ss_n got=%b exp=1", bus.SS_n); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (fw[0] !== 16'h00A5) begin n_fail++; $display("FAIL f8_word got=%h exp=00a5", fw[0]); end
        n_checks++; if (rises != 8) begin n_fail++; $display("FAIL f8_rises got=%0d exp=8", rises); end
        n_checks++; if (edges != 16) begin n_fail++; $display("FAIL f8_edges got=%0d exp=16", edges); end
        n_checks++; if (edges_ss_hi != 0) begin n_fail++; $display("FAIL f8_edges_ss_high got=%0d exp=0", edges_ss_hi); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL f8_done_count got=%0d exp=1", done_cnt); end
        n_checks++; if (bus.MOSI !== 1'b1) begin n_fail++; $display("FAIL f8_mosi_hold got=%b exp=1", bus.MOSI); end
        n_checks++; if (trig_cnt != 1) begin n_fail++; $display("FAIL f8_trig got=%0d exp=1", trig_cnt); end
    endtask

    task automatic test_frame16_edg0();
        int cyc;
        set_mon(1'b0, 1'b1, 16'hC3F0);
        clear_mon();
        do_wrt(16'hC3F0, 1'b0, 1'b1);
        n_checks++; if (bus.MOSI !== 1'b1) begin n_fail++; $display("FAIL f16_start_mosi got=%b exp=1", bus.MOSI); end
        wait_done(cyc);
        n_checks++; if (cyc + 1 != 137) begin n_fail++; $display("FAIL f16_wrt_to_done got=%0d exp=137", cyc + 1); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (fw[0] !== 16'hC3F0) begin n_fail++; $display("FAIL f16_word got=%h exp=c3f0", fw[0]); end
        n_checks++; if (falls != 16) begin n_fail++; $display("FAIL f16_falls got=%0d exp=16", falls); end
        n_checks++; if (edges != 32) begin n_fail++; $display("FAIL f16_edges got=%0d exp=32", edges); end
        n_checks++; if (edges_ss_hi != 0) begin n_fail++; $display("FAIL f16_edges_ss_high got=%0d exp=0", edges_ss_hi); end
        n_checks++; if (bus.MOSI !== 1'b0) begin n_fail++; $display("FAIL f16_mosi_hold got=%b exp=0", bus.MOSI); end
        n_checks++; if (trig_cnt != 1) begin n_fail++; $display("FAIL f16_trig got=%0d exp=1", trig_cnt); end
    endtask

    task automatic test_rst_midframe();
        int cyc;
        int guard;
        set_mon(1'b1, 1'b1, 16'h5A3C);
        clear_mon();
        do_wrt(16'hFFFF, 1'b1, 1'b1);
        guard = 0;
        while (falls < 5 && guard < WMAX) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++; if (falls != 5) begin n_fail++; $display("FAIL rst_mid_reach_fall5 got=%0d exp=5", falls); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (bus.SS_n !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ss_n got=%b exp=1", bus.SS_n); end
        n_checks++; if (bus.SCLK !== 1'b1) begin n_fail++; $display("FAIL rst_mid_sclk got=%b exp=1", bus.SCLK); end
        n_checks++; if (bus.MOSI !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mosi got=%b exp=0", bus.MOSI); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
        repeat (150) @(posedge clk);
        #1;
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_cnt); end
        clear_mon();
        do_wrt(16'h5A3C, 1'b1, 1'b1);
        wait_done(cyc);
        n_checks++; if (cyc + 1 != 137) begin n_fail++; $display("FAIL rst_mid_refr_len got=%0d exp=137", cyc + 1); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (fw[0] !== 16'h5A3C) begin n_fail++; $display("FAIL rst_mid_refr_word got=%h exp=5a3c", fw[0]); end
        n_checks++; if (trig_cnt != 1) begin n_fail++; $display("FAIL rst_mid_refr_trig got=%0d exp=1", trig_cnt); end
    endtask

`ifndef SPI_TX_QUEUE_EN
    task automatic test_wrt_while_busy();
        int cyc;
        set_mon(1'b1, 1'b0, 16'h0096);
        clear_mon();
        do_wrt(16'h0096, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        bus.wrt = 1'b1; bus.tx_data = 16'hFFFF; bus.edg = 1'b0; bus.len8_16 = 1'b1;
        @(posedge clk); #1;
        bus.wrt = 1'b0;
        wait_done(cyc);
        n_checks++; if (cyc + 22 != 73) begin n_fail++; $display("FAIL busy_wrt_len got=%0d exp=73", cyc + 22); end
        repeat (150) @(posedge clk);
        #1;
        n_checks++; if (fw[0] !== 16'h0096) begin n_fail++; $display("FAIL busy_wrt_word got=%h exp=0096", fw[0]); end
        n_checks++; if (rises != 8) begin n_fail++; $display("FAIL busy_wrt_rises got=%0d exp=8", rises); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_wrt_done_count got=%0d exp=1", done_cnt); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_wrt_busy got=%b exp=0", bus.busy); end
    endtask
`else
    task automatic test_queue();
        int cyc;
        set_mon(1'b1, 1'b0, 16'h003C);
        clear_mon();
        do_wrt(16'h003C, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        do_wrt(16'h0081, 1'b1, 1'b0);
        n_checks++; if (bus.hold_full !== 1'b1) begin n_fail++; $display("FAIL q_hold_full_set got=%b exp=1", bus.hold_full); end
        repeat (5) @(posedge clk);
        do_wrt(16'h00FF, 1'b0, 1'b1);
        n_checks++; if (bus.hold_full !== 1'b1) begin n_fail++; $display("FAIL q_hold_full_kept got=%b exp=1", bus.hold_full); end
        wait_done(cyc);
        n_checks++; if (bus.SS_n !== 1'b1) begin n_fail++; $display("FAIL q_gap_ss_n got=%b exp=1", bus.SS_n); end
        @(posedge clk); #1;
        n_checks++; if (bus.SS_n !== 1'b0) begin n_fail++; $display("FAIL q_gap_len_ss_n got=%b exp=0", bus.SS_n); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL q_second_busy got=%b exp=1", bus.busy); end
        n_checks++; if (bus.hold_full !== 1'b0) begin n_fail++; $display("FAIL q_hold_drained got=%b exp=0", bus.hold_full); end
        n_checks++; if (bus.MOSI !== 1'b1) begin n_fail++; $display("FAIL q_second_mosi got=%b exp=1", bus.MOSI); end
        wait_done(cyc);
        n_checks++; if (cyc + 1 != 73) begin n_fail++; $display("FAIL q_second_len got=%0d exp=73", cyc + 1); end
        repeat (200) @(posedge clk);
        #1;
        n_checks++; if (frames != 2) begin n_fail++; $display("FAIL q_frames got=%0d exp=2", frames); end
        n_checks++; if (fw[0] !== 16'h003C) begin n_fail++; $display("FAIL q_word0 got=%h exp=003c", fw[0]); end
        n_checks++; if (fw[1] !== 16'h0081) begin n_fail++; $display("FAIL q_word1 got=%h exp=0081", fw[1]); end
        n_checks++; if (done_cnt != 2) begin n_fail++; $display("FAIL q_done_count got=%0d exp=2", done_cnt); end
    endtask
`endif

    task automatic test_back_to_back();
        int cyc;
        set_mon(1'b1, 1'b0, 16'h00C4);
        clear_mon();
        do_wrt(16'h00C4, 1'b1, 1'b0);
        wait_done(cyc);
        n_checks++; if (cyc >= WMAX) begin n_fail++; $display("FAIL b2b_first_done got=timeout exp=done"); end
        bus.wrt = 1'b1; bus.tx_data = 16'h00B3; bus.edg = 1'b1; bus.len8_16 = 1'b0;
        @(posedge clk); #1;
        bus.wrt = 1'b0; bus.tx_data = 16'h0000;
        n_checks++; if (bus.SS_n !== 1'b0) begin n_fail++; $display("FAIL b2b_ss_n got=%b exp=0", bus.SS_n); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", bus.busy); end
        n_checks++; if (bus.MOSI !== 1'b1) begin n_fail++; $display("FAIL b2b_mosi got=%b exp=1", bus.MOSI); end
        wait_done(cyc);
        n_checks++; if (cyc + 1 != 73) begin n_fail++; $display("FAIL b2b_len got=%0d exp=73", cyc + 1); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (fw[0] !== 16'h00C4) begin n_fail++; $display("FAIL b2b_word0 got=%h exp=00c4", fw[0]); end
        n_checks++; if (fw[1] !== 16'h00B3) begin n_fail++; $display("FAIL b2b_word1 got=%h exp=00b3", fw[1]); end
        n_checks++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt); end
    endtask

    task automatic test_loopback();
        logic [15:0] d [0:3];
        logic        e [0:3];
        logic        l [0:3];
        int          cyc;
        d[0] = 16'h1234; e[0] = 1'b1; l[0] = 1'b1;
        d[1] = 16'h00E7; e[1] = 1'b0; l[1] = 1'b0;
        d[2] = 16'hBEEF; e[2] = 1'b0; l[2] = 1'b1;
        d[3] = 16'h0042; e[3] = 1'b1; l[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_mon(e[i], l[i], d[i]);
            clear_mon();
            do_wrt(d[i], e[i], l[i]);
            wait_done(cyc);
            repeat (4) @(posedge clk);
            #1;
            n_checks++;
            if (trig_cnt != 1 || frames != 1) begin
                n_fail++;
                $display("FAIL loopback_%0d trig got=%0d frames=%0d word=%h exp trig=1 frames=1 word=%h",
                         i, trig_cnt, frames, fw[0], d[i]);
            end
        end
    endtask

    initial begin
        bus.wrt = 1'b0; bus.tx_data = 16'h0000; bus.edg = 1'b1; bus.len8_16 = 1'b0;
        test_reset();
        test_frame8_edg1();
        test_frame16_edg0();
        test_rst_midframe();
`ifdef SPI_TX_QUEUE_EN
        test_queue();
`else
        test_wrt_while_busy();
`endif
        test_back_to_back();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
